// File: rtl/vproc_bus_responder.sv
// VProc bus target: word-addressed RAM, control registers and a delayed interrupt generator.
// Define VPROC_RESP_TIMER_EN to add the free-running cycle counter at register 0x3.
module vproc_bus_responder #(
    parameter int unsigned MEM_ABITS   = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [3:0]  REG_NIBBLE  = 4'hF
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    output logic [2:0]  Interrupt
);

    localparam int unsigned MemDepth = 1 << MEM_ABITS;
    localparam logic [7:0]  WaitCnt  = WAIT_STATES[7:0];

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StExec,
        StAck
    } state_e;

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       capture;

    logic [3:0]           cap_nib_q;
    logic [MEM_ABITS-1:0] cap_word_q;
    logic [31:0]          cap_data_q;
    logic                 cap_we_q;
    logic                 cap_rd_q;

    logic        is_reg;
    logic [1:0]  reg_sel;
    logic        exec;
    logic        wr_acc;
    logic        rd_acc;
    logic        reg_we;
    logic        mem_we;
    logic [31:0] rd_data;
    logic [31:0] timer_rd;

    logic [31:0] data_in_q;
    logic        wr_ack_q;
    logic        rd_ack_q;

    logic [31:0] int_ctrl_q, int_ctrl_d;
    logic [15:0] dly_q, dly_d;
    logic        armed_q, armed_d;
    logic [2:0]  irq_q, irq_d;

    logic [31:0] mem [MemDepth];

    // Address bits that alias away in both the RAM and register spaces.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr[27:MEM_ABITS+2], Addr[1:0]};

    // Request handshake FSM
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (WE || RD) begin
                    capture = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitCnt;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StExec;
                end
            end
            StExec: state_d = StAck;
            // Request lines are still the stale ones here; never sample them.
            StAck:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cap_nib_q  <= '0;
            cap_word_q <= '0;
            cap_data_q <= '0;
            cap_we_q   <= 1'b0;
            cap_rd_q   <= 1'b0;
        end else if (capture) begin
            cap_nib_q  <= Addr[31:28];
            cap_word_q <= Addr[MEM_ABITS+1:2];
            cap_data_q <= DataOut;
            cap_we_q   <= WE;
            cap_rd_q   <= RD;
        end
    end

    assign is_reg  = (cap_nib_q == REG_NIBBLE);
    assign reg_sel = cap_word_q[1:0];
    assign exec    = (state_q == StExec);
    assign wr_acc  = exec && cap_we_q;
    assign rd_acc  = exec && cap_rd_q;
    assign reg_we  = wr_acc && is_reg;
    assign mem_we  = wr_acc && !is_reg;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[cap_word_q] <= cap_data_q;
        end
    end

    always_comb begin
        rd_data = '0;
        if (is_reg) begin
            unique case (reg_sel)
                2'd0: rd_data = int_ctrl_q;
                2'd1: rd_data = '0;
                2'd2: rd_data = {16'h0000, WaitCnt, 4'h0, irq_q, armed_q};
                2'd3: rd_data = timer_rd;
                default: rd_data = '0;
            endcase
        end else begin
            rd_data = mem[cap_word_q];
        end
    end

    // Read data sampled before the write lands, so WE+RD returns the old word.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            data_in_q <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
        end else begin
            wr_ack_q <= wr_acc;
            rd_ack_q <= rd_acc;
            if (rd_acc) begin
                data_in_q <= rd_data;
            end
        end
    end

    // Interrupt generator; a register write overrides the countdown in the same cycle.
    always_comb begin
        int_ctrl_d = int_ctrl_q;
        dly_d      = dly_q;
        armed_d    = armed_q;
        irq_d      = irq_q;
        if (armed_q) begin
            if (dly_q == 16'd0) begin
                irq_d   = int_ctrl_q[2:0];
                armed_d = 1'b0;
            end else begin
                dly_d = dly_q - 16'd1;
            end
        end
        if (reg_we && (reg_sel == 2'd0)) begin
            int_ctrl_d = cap_data_q;
            dly_d      = cap_data_q[31:16];
            armed_d    = 1'b1;
            irq_d      = 3'd0;
        end else if (reg_we && (reg_sel == 2'd1)) begin
            armed_d = 1'b0;
            irq_d   = 3'd0;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            int_ctrl_q <= '0;
            dly_q      <= '0;
            armed_q    <= 1'b0;
            irq_q      <= 3'd0;
        end else begin
            int_ctrl_q <= int_ctrl_d;
            dly_q      <= dly_d;
            armed_q    <= armed_d;
            irq_q      <= irq_d;
        end
    end

`ifdef VPROC_RESP_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] cap_timer_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            timer_q <= '0;
        end else if (reg_we && (reg_sel == 2'd3)) begin
            timer_q <= cap_data_q;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Reads report the count as it stood when the request was captured.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cap_timer_q <= '0;
        end else if (capture) begin
            cap_timer_q <= timer_q;
        end
    end

    assign timer_rd = cap_timer_q;
`else
    assign timer_rd = '0;
`endif

    assign DataIn    = data_in_q;
    assign WRAck     = wr_ack_q;
    assign RDAck     = rd_ack_q;
    assign Interrupt = irq_q;

endmodule
